// File: rtl/hbus_arbiter.sv
// Round-robin arbiter sharing one memory port between per-hart L2 buses; writes drain before reads.
// Define HBUS_INV_EN to pulse line invalidations to the other harts after each acked write.
module hbus_arbiter #(
  parameter int HARTS      = 2,
  parameter int LINE       = 512,
  parameter int WBUF_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [HARTS*64-1:0]     h_addr,
  input  logic [HARTS-1:0]        h_rd,
  output logic [HARTS-1:0]        h_dv,
  output logic [LINE-1:0]         h_data_in,
  input  logic [HARTS*LINE-1:0]   h_data_out,
  input  logic [HARTS-1:0]        h_wr,
  output logic [HARTS-1:0]        inv,
  output logic [63:0]             inv_addr,
  output logic [63:0]             m_addr,
  output logic                    m_rd,
  input  logic                    m_dv,
  input  logic [LINE-1:0]         m_data_in,
  output logic                    m_wr,
  input  logic                    m_wack,
  output logic [LINE-1:0]         m_data_out,
  output logic [HARTS-1:0]        grant,
  output logic [HARTS-1:0]        wbuf_ovf
);

  localparam int IDXW = $clog2(HARTS);
  localparam int PW   = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW   = $clog2(WBUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e            state_q, state_d;
  logic [HARTS-1:0]  grant_q, grant_d;
  logic [IDXW-1:0]   gIdx_q, gIdx_d;
  logic [IDXW-1:0]   rr_q, rr_d;
  logic [63:0]       mAddr_q, mAddr_d;
  logic [LINE-1:0]   mDataOut_q, mDataOut_d;
  logic              mRd_q, mRd_d;
  logic              mWr_q, mWr_d;
  logic [HARTS-1:0]  hDv_q, hDv_d;
  logic [LINE-1:0]   hDataIn_q, hDataIn_d;
  logic [HARTS-1:0]  maskA_q, maskA_d;
  logic [HARTS-1:0]  maskB_q;
  logic [HARTS-1:0]  ovf_q;

  logic [63:0]       fAddr_q [HARTS][WBUF_DEPTH];
  logic [LINE-1:0]   fData_q [HARTS][WBUF_DEPTH];
  logic [PW-1:0]     wrPtr_q [HARTS];
  logic [PW-1:0]     rdPtr_q [HARTS];
  logic [CW-1:0]     cnt_q   [HARTS];

  logic [HARTS-1:0]  wrReq, rdReq, reqVec, pushVec, popVec;
  logic              anyWr;
  logic [IDXW-1:0]   pickIdx, idx;
  logic [63:0]       headAddr [HARTS];
  logic [LINE-1:0]   headData [HARTS];

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    nextPtr = (p == PW'(WBUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // An empty FIFO with a write arriving this cycle competes with the incoming line itself.
  always_comb begin
    wrReq = '0;
    for (int i = 0; i < HARTS; i++) begin
      wrReq[i]    = (cnt_q[i] != '0) || h_wr[i];
      headAddr[i] = (cnt_q[i] != '0) ? fAddr_q[i][rdPtr_q[i]] : h_addr[64*i +: 64];
      headData[i] = (cnt_q[i] != '0) ? fData_q[i][rdPtr_q[i]] : h_data_out[LINE*i +: LINE];
    end
    rdReq   = h_rd & ~(maskA_q | maskB_q);
    anyWr   = |wrReq;
    reqVec  = anyWr ? wrReq : rdReq;
    pickIdx = '0;
    idx     = '0;
    for (int k = HARTS - 1; k >= 0; k--) begin
      idx = IDXW'((int'(rr_q) + k) % HARTS);
      if (reqVec[idx]) pickIdx = idx;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gIdx_d     = gIdx_q;
    rr_d       = rr_q;
    mAddr_d    = mAddr_q;
    mDataOut_d = mDataOut_q;
    mRd_d      = mRd_q;
    mWr_d      = mWr_q;
    hDv_d      = '0;
    hDataIn_d  = hDataIn_q;
    maskA_d    = '0;
    popVec     = '0;
    case (state_q)
      IDLE: begin
        if (|reqVec) begin
          grant_d          = '0;
          grant_d[pickIdx] = 1'b1;
          gIdx_d           = pickIdx;
          rr_d             = (pickIdx == IDXW'(HARTS - 1)) ? '0 : pickIdx + IDXW'(1);
          if (anyWr) begin
            state_d    = WRITE;
            mWr_d      = 1'b1;
            mAddr_d    = headAddr[pickIdx];
            mDataOut_d = headData[pickIdx];
          end else begin
            state_d = READ;
            mRd_d   = 1'b1;
            mAddr_d = h_addr[64*int'(pickIdx) +: 64];
          end
        end
      end
      READ: begin
        if (m_dv) begin
          state_d        = IDLE;
          grant_d        = '0;
          mRd_d          = 1'b0;
          hDv_d[gIdx_q]  = 1'b1;
          hDataIn_d      = m_data_in;
          maskA_d[gIdx_q] = 1'b1;
        end
      end
      WRITE: begin
        if (m_wack) begin
          state_d        = IDLE;
          grant_d        = '0;
          mWr_d          = 1'b0;
          popVec[gIdx_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The hart keeps h_rd up one cycle past h_dv, so its request is masked for two decisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gIdx_q     <= '0;
      rr_q       <= '0;
      mAddr_q    <= '0;
      mDataOut_q <= '0;
      mRd_q      <= 1'b0;
      mWr_q      <= 1'b0;
      hDv_q      <= '0;
      hDataIn_q  <= '0;
      maskA_q    <= '0;
      maskB_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gIdx_q     <= gIdx_d;
      rr_q       <= rr_d;
      mAddr_q    <= mAddr_d;
      mDataOut_q <= mDataOut_d;
      mRd_q      <= mRd_d;
      mWr_q      <= mWr_d;
      hDv_q      <= hDv_d;
      hDataIn_q  <= hDataIn_d;
      maskA_q    <= maskA_d;
      maskB_q    <= maskA_q;
    end
  end

  always_comb begin
    pushVec = '0;
    for (int i = 0; i < HARTS; i++) begin
      pushVec[i] = h_wr[i] && ((cnt_q[i] != CW'(WBUF_DEPTH)) || popVec[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
      for (int i = 0; i < HARTS; i++) begin
        cnt_q[i]   <= '0;
        wrPtr_q[i] <= '0;
        rdPtr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < HARTS; i++) begin
        if (pushVec[i]) wrPtr_q[i] <= nextPtr(wrPtr_q[i]);
        if (popVec[i]) rdPtr_q[i] <= nextPtr(rdPtr_q[i]);
        if (pushVec[i] && !popVec[i]) cnt_q[i] <= cnt_q[i] + CW'(1);
        else if (!pushVec[i] && popVec[i]) cnt_q[i] <= cnt_q[i] - CW'(1);
        if (h_wr[i] && !pushVec[i]) ovf_q[i] <= 1'b1;
      end
    end
  end

  // Storage needs no reset; emptiness is tracked by the counters alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < HARTS; i++) begin
      if (pushVec[i]) begin
        fAddr_q[i][wrPtr_q[i]] <= h_addr[64*i +: 64];
        fData_q[i][wrPtr_q[i]] <= h_data_out[LINE*i +: LINE];
      end
    end
  end

`ifdef HBUS_INV_EN
  logic [HARTS-1:0] inv_q, inv_d;
  logic [63:0]      invAddr_q, invAddr_d;

  always_comb begin
    inv_d     = '0;
    invAddr_d = invAddr_q;
    if (state_q == WRITE && m_wack) begin
      inv_d     = ~grant_q;
      invAddr_d = mAddr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q     <= '0;
      invAddr_q <= '0;
    end else begin
      inv_q     <= inv_d;
      invAddr_q <= invAddr_d;
    end
  end

  assign inv      = inv_q;
  assign inv_addr = invAddr_q;
`else
  assign inv      = '0;
  assign inv_addr = '0;
`endif

  assign h_dv       = hDv_q;
  assign h_data_in  = hDataIn_q;
  assign m_addr     = mAddr_q;
  assign m_rd       = mRd_q;
  assign m_wr       = mWr_q;
  assign m_data_out = mDataOut_q;
  assign grant      = grant_q;
  assign wbuf_ovf   = ovf_q;

endmodule

// File: tb/tb_hbus_arbiter.sv
// Bench for hbus_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_hbus_arbiter;

  localparam int HARTS = 2;
  localparam int LINE  = 512;
  localparam int DEPTH = 2;

  logic                  clk;
  logic                  rst;
  logic [HARTS*64-1:0]   h_addr;
  logic [HARTS-1:0]      h_rd, h_dv, h_wr, inv, grant, wbuf_ovf;
  logic [LINE-1:0]       h_data_in, m_data_in, m_data_out;
  logic [HARTS*LINE-1:0] h_data_out;
  logic [63:0]           inv_addr, m_addr;
  logic                  m_rd, m_dv, m_wr, m_wack;

  hbus_arbiter #(.HARTS(HARTS), .LINE(LINE), .WBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .h_addr(h_addr), .h_rd(h_rd), .h_dv(h_dv),
    .h_data_in(h_data_in), .h_data_out(h_data_out), .h_wr(h_wr), .inv(inv),
    .inv_addr(inv_addr), .m_addr(m_addr), .m_rd(m_rd), .m_dv(m_dv),
    .m_data_in(m_data_in), .m_wr(m_wr), .m_wack(m_wack), .m_data_out(m_data_out),
    .grant(grant), .wbuf_ovf(wbuf_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]     a;
    logic [LINE-1:0] d;
  } wEnt_t;

  wEnt_t wq [HARTS][$];
  int    maskLeft [HARTS];
  int    post [HARTS];
  bit    mBusy, mIsWr;
  int    mOwn, mRr;
  logic [HARTS-1:0] eGrant, eDv, eInv, eOvf;
  logic             eMrd, eMwr;
  logic [63:0]      eMaddr, eInvAddr;
  logic [LINE-1:0]  eDataIn, eDataOut;
  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [LINE-1:0] obs, input logic [LINE-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE-1:0] randLine();
    logic [LINE-1:0] r;
    for (int i = 0; i < LINE / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] randAddr();
    return {48'h0, 10'($urandom_range(0, 1023)), 6'h0};
  endfunction

  // Reference: per-hart write queues, rr pointer and a two-decision read mask, stepped once per edge.
  task automatic modelStep();
    int pick, h, popH;
    bit any, want, decided;
    logic [HARTS-1:0] oh;
    wEnt_t ent;
    if (rst) begin
      for (int i = 0; i < HARTS; i++) begin
        wq[i].delete();
        maskLeft[i] = 0;
      end
      mBusy = 0; mRr = 0;
      eGrant = '0; eDv = '0; eInv = '0; eOvf = '0; eMrd = 0; eMwr = 0;
      eMaddr = '0; eInvAddr = '0; eDataIn = '0; eDataOut = '0;
      return;
    end
    eDv = '0; eInv = '0; decided = 0; popH = -1;
    if (!mBusy) begin
      any = 0;
      for (int i = 0; i < HARTS; i++) if (wq[i].size() > 0 || h_wr[i]) any = 1;
      pick = -1;
      for (int k = 0; k < HARTS; k++) begin
        h = (mRr + k) % HARTS;
        want = any ? (wq[h].size() > 0 || h_wr[h]) : (h_rd[h] && maskLeft[h] == 0);
        if (want && pick < 0) pick = h;
      end
      if (pick >= 0) begin
        mBusy = 1; mOwn = pick; mIsWr = any; mRr = (pick + 1) % HARTS; decided = 1;
        eGrant = '0; eGrant[pick] = 1'b1;
        if (any) begin
          if (wq[pick].size() > 0) ent = wq[pick][0];
          else begin
            ent.a = h_addr[64*pick +: 64];
            ent.d = h_data_out[LINE*pick +: LINE];
          end
          eMaddr = ent.a; eDataOut = ent.d; eMwr = 1;
        end else begin
          eMaddr = h_addr[64*pick +: 64]; eMrd = 1;
        end
      end
    end
    for (int i = 0; i < HARTS; i++) if (maskLeft[i] > 0) maskLeft[i]--;
    if (mBusy && !decided) begin
      if (!mIsWr && m_dv) begin
        eDv[mOwn] = 1'b1; eDataIn = m_data_in; maskLeft[mOwn] = 2;
        eMrd = 0; eGrant = '0; mBusy = 0;
      end else if (mIsWr && m_wack) begin
        popH = mOwn; eMwr = 0; eGrant = '0; mBusy = 0;
`ifdef HBUS_INV_EN
        oh = '0; oh[mOwn] = 1'b1;
        eInv = ~oh; eInvAddr = eMaddr;
`endif
      end
    end
    for (int i = 0; i < HARTS; i++) if (popH == i) void'(wq[i].pop_front());
    for (int i = 0; i < HARTS; i++) begin
      if (h_wr[i]) begin
        if (wq[i].size() < DEPTH) begin
          ent.a = h_addr[64*i +: 64];
          ent.d = h_data_out[LINE*i +: LINE];
          wq[i].push_back(ent);
        end else eOvf[i] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    modelStep();
    checkOutput("grant", grant, eGrant);
    checkOutput("m_rd", m_rd, eMrd);
    checkOutput("m_wr", m_wr, eMwr);
    checkOutput("m_addr", m_addr, eMaddr);
    checkOutput("m_data_out", m_data_out, eDataOut);
    checkOutput("h_dv", h_dv, eDv);
    checkOutput("h_data_in", h_data_in, eDataIn);
    checkOutput("inv", inv, eInv);
    checkOutput("inv_addr", inv_addr, eInvAddr);
    checkOutput("wbuf_ovf", wbuf_ovf, eOvf);
  endtask

  task automatic resetDut();
    rst = 1; h_rd = '0; h_wr = '0; m_dv = 0; m_wack = 0;
    for (int i = 0; i < HARTS; i++) post[i] = 0;
    tick();
    tick();
    rst = 0;
  endtask

  // Harts hold reads until h_dv plus one cycle; writes are one-cycle pulses only while not reading.
  task automatic applyStimulus();
    int r;
    rst  = ($urandom_range(0, 299) == 0);
    h_wr = '0;
    for (int i = 0; i < HARTS; i++) begin
      if (h_dv[i]) post[i] = 2;
      else if (post[i] > 0) begin
        post[i]--;
        if (post[i] == 0) h_rd[i] = 1'b0;
      end else if (!h_rd[i]) begin
        r = $urandom_range(0, 7);
        if (r < 2) begin
          h_wr[i] = 1'b1;
          h_addr[64*i +: 64] = randAddr();
          h_data_out[LINE*i +: LINE] = randLine();
        end else if (r == 2) begin
          h_rd[i] = 1'b1;
          h_addr[64*i +: 64] = randAddr();
        end
      end
    end
    m_dv      = m_rd ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
    m_wack    = m_wr ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
    m_data_in = randLine();
  endtask

  initial begin
    logic [LINE-1:0] pat;
    logic [HARTS-1:0] prev;
    int n;
    h_addr = '0; h_data_out = '0; m_data_in = '0;
    resetDut();

    $display("[TB] single read");
    h_rd[0] = 1; h_addr[63:0] = 64'h1000;
    tick();
    checkOutput("t1_maddr", m_addr, 64'h1000);
    tick();
    tick();
    pat = randLine();
    m_dv = 1; m_data_in = pat;
    tick();
    checkOutput("t1_dv", h_dv, 2'b01);
    checkOutput("t1_data", h_data_in, pat);
    m_dv = 0;
    tick();
    checkOutput("t1_norerd", m_rd, 1'b0);
    h_rd[0] = 0;
    tick();
    checkOutput("t1_norerd2", m_rd, 1'b0);

    $display("[TB] round robin");
    resetDut();
    h_rd = 2'b11; h_addr[63:0] = 64'h1000; h_addr[127:64] = 64'h1040;
    n = 0; prev = '0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      m_dv = m_rd; m_data_in = randLine();
      tick();
      if (grant != '0 && prev == '0) begin
        checkOutput($sformatf("rr_grant%0d", n), grant, (n % 2 == 0) ? 2'b01 : 2'b10);
        n++;
      end
      prev = grant;
    end
    checkOutput("rr_count", n, 4);

    $display("[TB] write priority");
    resetDut();
    h_rd[1] = 1; h_addr[127:64] = 64'h5000;
    h_wr[0] = 1; h_addr[63:0] = 64'h2040; h_data_out[LINE-1:0] = randLine();
    tick();
    checkOutput("wp_mwr", m_wr, 1'b1);
    checkOutput("wp_waddr", m_addr, 64'h2040);
    h_wr = '0;
    tick();
    m_wack = 1;
    tick();
    m_wack = 0;
    tick();
    checkOutput("wp_mrd", m_rd, 1'b1);
    checkOutput("wp_raddr", m_addr, 64'h5000);
    checkOutput("wp_rgrant", grant, 2'b10);

    $display("[TB] overflow");
    resetDut();
    h_wr[0] = 1; h_addr[63:0] = 64'hA000; h_data_out[LINE-1:0] = randLine();
    tick();
    h_addr[63:0] = 64'hA040; h_data_out[LINE-1:0] = randLine();
    tick();
    h_addr[63:0] = 64'hA080; h_data_out[LINE-1:0] = randLine();
    tick();
    checkOutput("ov_flag", wbuf_ovf, 2'b01);
    h_wr = '0;
    m_wack = 1;
    tick();
    m_wack = 0;
    tick();
    checkOutput("ov_second", m_addr, 64'hA040);
    m_wack = 1;
    tick();
    m_wack = 0;
    tick();
    checkOutput("ov_dropped", m_wr, 1'b0);
    checkOutput("ov_sticky", wbuf_ovf, 2'b01);

    $display("[TB] invalidate");
    resetDut();
    h_wr[1] = 1; h_addr[127:64] = 64'h3000; h_data_out[2*LINE-1:LINE] = randLine();
    tick();
    h_wr = '0;
    m_wack = 1;
    tick();
`ifdef HBUS_INV_EN
    checkOutput("inv_pulse", inv, 2'b01);
    checkOutput("inv_line", inv_addr, 64'h3000);
`else
    checkOutput("inv_pulse", inv, 2'b00);
    checkOutput("inv_line", inv_addr, 64'h0);
`endif
    m_wack = 0;
    tick();
    checkOutput("inv_clear", inv, 2'b00);

    $display("[TB] reset mid-read");
    resetDut();
    h_rd[0] = 1; h_addr[63:0] = 64'h1000;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0; h_rd = '0; m_dv = 1;
    tick();
    checkOutput("rm_dv", h_dv, 2'b00);
    checkOutput("rm_mrd", m_rd, 1'b0);
    checkOutput("rm_grant", grant, 2'b00);
    m_dv = 0;

    $display("[TB] random traffic");
    resetDut();
    for (int c = 0; c < 1500; c++) begin
      applyStimulus();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hbus_arbiter.md
Name: hbus_arbiter

Overview:
- Shares one external memory port between N per-hart L2 cache external buses (h_addr/h_rd/h_dv/h_data_in/h_data_out/h_wr).
- Reads are held-level requests. Writes are single-cycle pulses with no back-pressure, so each hart has a small write FIFO.
- Arbitration is round-robin. Pending writes always drain before any read, which preserves write-through ordering.
- Optionally broadcasts line invalidations to the other harts.

Parameters:
- HARTS, 2, number of requesting harts (≥2).
- LINE, 512, cache line width in bits (hart and memory side).
- WBUF_DEPTH, 2, write FIFO entries per hart (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- h_addr  in  HARTS*64  line-aligned address per hart, slice i = [64*i +: 64]
- h_rd  in  HARTS  read request, held until served
- h_dv  out  HARTS  read data valid, one-cycle pulse
- h_data_in  out  LINE  read line, shared by all harts, valid with h_dv
- h_data_out  in  HARTS*LINE  write line per hart
- h_wr  in  HARTS  write pulse, captured the same cycle
- inv  out  HARTS  invalidate pulse per hart
- inv_addr  out  64  line address for inv
- m_addr  out  64  memory address
- m_rd  out  1  memory read, held until m_dv
- m_dv  in  1  memory read data valid
- m_data_in  in  LINE  memory read line
- m_wr  out  1  memory write, held until m_wack
- m_wack  in  1  memory write accepted
- m_data_out  out  LINE  memory write line
- grant  out  HARTS  one-hot current owner, 0 when idle
- wbuf_ovf  out  HARTS  sticky write-FIFO overflow flag

Behaviour:
- Reset, synchronous and active-high:
  - FSM goes to IDLE; all FIFOs are emptied; rr pointer = 0; masks are cleared.
  - All outputs are 0: h_dv, inv, m_rd, m_wr, grant, wbuf_ovf, m_addr, inv_addr, h_data_in, m_data_out.
  - Reset mid-transaction drops the transaction. A late m_dv or m_wack is ignored in IDLE.
- Write capture:
  - h_wr[i]=1 pushes {h_addr slice, h_data_out slice} into FIFO i that cycle, independent of FSM state.
  - Push when full (and no simultaneous pop): data is dropped and wbuf_ovf[i] is set until rst.
  - Push and pop in the same cycle on a full FIFO is legal.
- Arbitration, IDLE only, one decision per cycle:
  - If any FIFO is non-empty, pick the first non-empty hart at or after rr (modulo HARTS) → WRITE.
  - Otherwise pick the first hart with h_rd[i]=1 and rd_mask[i]=0 → READ.
  - On grant: register grant and m_addr (and m_data_out for a write); rr <= g+1 mod HARTS.
  - m_rd or m_wr asserts the cycle after the request is seen (1-cycle arbitration latency).
- READ:
  - m_rd stays high until m_dv.
  - On m_dv: h_data_in <= m_data_in and h_dv[g] <= 1 for exactly one cycle (registered, +1 cycle).
  - Then rd_mask[g] is set for the next 2 cycles, because the hart keeps h_rd high one cycle past h_dv. Return to IDLE.
- WRITE:
  - m_wr stays high until m_wack.
  - On m_wack: pop FIFO g and return to IDLE. m_wr drops the following cycle.
- Idle bus: m_rd and m_wr are never both high; grant is 0 in IDLE.
- Back-to-back: a new grant is possible the cycle the FSM returns to IDLE, so the minimum gap between memory transactions is 1 idle cycle.
- A single hart's write to line X followed by its read of X: the write always reaches memory first.

Optional Feature:
- HBUS_INV_EN defined:
  - The cycle after m_wack of a write from hart g, inv[j] pulses for one cycle for every j≠g.
  - inv_addr = written line address. inv[g] stays 0.
- Not defined: inv = 0 and inv_addr = 0 permanently; no invalidation logic is built.

Test Plan:
- Single read: hart0 h_rd, h_addr=0x1000; memory m_dv 3 cycles after m_rd → m_addr=0x1000, one h_dv[0] pulse with h_data_in=m_data_in, no second m_rd while hart0 h_rd stays high one extra cycle.
- Round-robin: h_rd=2'b11 held continuously, HARTS=2 → grants alternate 0,1,0,1; neither hart starves.
- Write priority: hart1 h_rd pending, hart0 h_wr at 0x2040 same cycle → memory sees m_wr 0x2040 first, then m_rd for hart1.
- Overflow: hart0 issues 3 h_wr pulses while m_wack is held low → first two are preserved in order, third is dropped, wbuf_ovf[0]=1 until rst.
- Invalidate (HBUS_INV_EN): hart1 write 0x3000 acked → inv=2'b01 for one cycle with inv_addr=0x3000. Without the macro → inv stays 0.
- Reset mid-read: rst asserted while m_rd=1, then m_dv arrives → no h_dv, all outputs 0, FSM in IDLE.
